// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, owner and strobe encodings for the memory arbiter
package mem_arbiter_pkg;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    localparam logic [3:0] WEN_NONE = 4'b0000;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store requests onto one single-port memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TIMEOUT   = 15,
    parameter int RR_ENABLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic [3:0]       d_wen,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [3:0]       mem_wen,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             err
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    arb_state_t       r_state, w_next_state;
    owner_t           r_owner, r_last_owner, w_grant_owner;
    logic [3:0]       r_wen;
    logic [WIDTH-1:0] r_addr, r_wdata;
    logic [CW-1:0]    r_cnt;
    logic             w_grant, w_done, w_timeout;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next_state;
    end

    // valid drops combinationally in the completion cycle so a write is never presented twice
    always_comb begin
        w_grant       = r_state == ARB_IDLE && (i_valid || d_valid);
        w_grant_owner = (d_valid && (!i_valid || RR_ENABLE == 0 || r_last_owner == OWN_I)) ? OWN_D : OWN_I;
        w_done        = r_state == ARB_BUSY && mem_ready;
        w_timeout     = r_state == ARB_BUSY && !mem_ready && r_cnt == CW'(TIMEOUT - 1);
        w_next_state  = w_grant ? ARB_BUSY : (w_done || w_timeout) ? ARB_IDLE : r_state;
        mem_valid     = r_state == ARB_BUSY && !mem_ready;
        i_ready       = w_done && r_owner == OWN_I;
        d_ready       = w_done && r_owner == OWN_D;
        err           = w_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_I;
            r_last_owner <= OWN_D;
            r_wen        <= WEN_NONE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
        end else if (w_grant) begin
            r_owner <= w_grant_owner;
            r_wen   <= w_grant_owner == OWN_D ? d_wen : WEN_NONE;
            r_addr  <= w_grant_owner == OWN_D ? d_addr : i_addr;
            r_wdata <= w_grant_owner == OWN_D ? d_wdata : '0;
            r_cnt   <= '0;
        end else if (w_done || w_timeout) begin
            r_last_owner <= r_owner;
        end else if (r_state == ARB_BUSY) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign mem_wen   = r_wen;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, corner sequences and randomized traffic against a shadow memory
module tb_mem_arbiter;
    logic        clk = 0, rst = 1;
    logic        i_valid = 0, d_valid = 0, i2_valid = 0, d2_valid = 0;
    logic [3:0]  d_wen = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic        i_ready, d_ready, mem_valid, err, mem_ready;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wen;
    logic        i2_ready, d2_ready, mem2_valid, err2;
    logic [31:0] i2_rdata, d2_rdata, mem2_addr, mem2_wdata;
    logic [3:0]  mem2_wen;
    logic        ack = 0, stale = 0, ack2 = 0;
    logic [31:0] rdata = 0, rdata2 = 0;
    logic [31:0] mem [64];
    logic [31:0] shadow [64];
    int          lat = 1, wt = 0, writes = 0, n_cmp = 0, n_fail = 0;
    logic        mem_en = 1;

    typedef struct {
        logic        is_d;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [8];

    always #5 clk = ~clk;
    assign mem_ready = ack | stale;

    mem_arbiter #(.WIDTH(32), .TIMEOUT(15), .RR_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_wen(d_wen), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata), .err(err)
    );

    mem_arbiter #(.WIDTH(32), .TIMEOUT(15), .RR_ENABLE(0)) dut_pri (
        .clk(clk), .rst(rst),
        .i_valid(i2_valid), .i_ready(i2_ready), .i_addr(i_addr), .i_rdata(i2_rdata),
        .d_valid(d2_valid), .d_ready(d2_ready), .d_wen(d_wen), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d2_rdata),
        .mem_valid(mem2_valid), .mem_ready(ack2), .mem_wen(mem2_wen),
        .mem_addr(mem2_addr), .mem_wdata(mem2_wdata), .mem_rdata(rdata2), .err(err2)
    );

    // memory answers after lat cycles of valid; the write lands on the completing edge
    always @(posedge clk) begin
        if (!mem_en || ack || !mem_valid) begin
            ack <= 0;
            wt  <= 0;
        end else if (wt == lat - 1) begin
            ack   <= 1;
            rdata <= mem[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (|mem_wen) writes <= writes + 1;
            wt <= 0;
        end else begin
            wt <= wt + 1;
        end
    end

    always @(posedge clk) begin
        ack2   <= mem2_valid && !ack2;
        rdata2 <= mem2_addr ^ 32'hA5A50000;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] w);
        logic [31:0] m;
        m = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (old & ~m) | (wd & m);
    endfunction

    task automatic xfer(input vec_t v);
        int w0;
        @(negedge clk);
        w0      = writes;
        i_valid = !v.is_d;
        d_valid = v.is_d;
        i_addr  = v.addr;
        d_addr  = v.addr;
        d_wen   = v.is_d ? v.wen : 4'hF;
        d_wdata = v.is_d ? v.wdata : 32'hFFFF_FFFF;
        @(negedge clk);
        chk("xf_mem_valid", mem_valid, 1);
        chk("xf_mem_wen", mem_wen, v.is_d ? v.wen : 4'h0);
        chk("xf_mem_addr", mem_addr, v.addr);
        chk("xf_mem_wdata", mem_wdata, v.is_d ? v.wdata : 32'h0);
        chk("xf_early_ready", {i_ready, d_ready}, 0);
        @(negedge clk);
        chk("xf_ready", {i_ready, d_ready}, v.is_d ? 2'b01 : 2'b10);
        chk("xf_mem_valid_done", mem_valid, 0);
        if (v.wen == 0 || !v.is_d) chk("xf_rdata", v.is_d ? d_rdata : i_rdata, v.exp);
        i_valid = 0;
        d_valid = 0;
        @(negedge clk);
        chk("xf_writes", writes - w0, (v.is_d && v.wen != 0) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ek, nerr, n, w0, k2d, k2i;
        logic pi, pd;
        logic [31:0] ia, da, dd;
        logic [3:0] dwn;
        int ai, ad;
        for (int i = 0; i < 64; i++) mem[i] = (i * 32'h01010101) ^ 32'h9E3779B9;
        mem[4] = 32'h00018EB7;
        mem[2] = 32'h11223344;
        vt[0] = '{1'b0, 4'h0, 32'h10, 32'h0,        32'h00018EB7};
        vt[1] = '{1'b1, 4'h3, 32'h08, 32'hAABBCCDD, 32'h0};
        vt[2] = '{1'b1, 4'h0, 32'h08, 32'h0,        32'h1122CCDD};
        vt[3] = '{1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 32'h0};
        vt[4] = '{1'b1, 4'h0, 32'h20, 32'h0,        32'hDEADBEEF};
        vt[5] = '{1'b0, 4'h0, 32'h20, 32'h0,        32'hDEADBEEF};
        vt[6] = '{1'b1, 4'h8, 32'h20, 32'h12000000, 32'h0};
        vt[7] = '{1'b0, 4'h0, 32'h20, 32'h0,        32'h12ADBEEF};
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ready", {i_ready, d_ready}, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 0;
        for (int i = 0; i < 8; i++) xfer(vt[i]);

        @(negedge clk);
        stale = 1;
        #1;
        chk("stale_ready", {i_ready, d_ready}, 0);
        chk("stale_mem_valid", mem_valid, 0);
        @(negedge clk);
        stale = 0;
        chk("stale_idle", mem_valid, 0);

        @(negedge clk);
        mem_en  = 0;
        i_valid = 1;
        i_addr  = 32'h10;
        ek = 0;
        nerr = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("to_ready", {i_ready, d_ready}, 0);
            if (ek != 0 && k == ek + 1) chk("to_idle", mem_valid, 0);
            if (err) begin
                nerr++;
                if (ek == 0) ek = k;
                i_valid = 0;
            end
        end
        chk("to_err_cycle", ek, 15);
        chk("to_err_count", nerr, 1);
        mem_en = 1;
        xfer(vt[0]);

        @(negedge clk);
        lat = 3;
        w0 = writes;
        d_valid = 1;
        d_wen = 4'hF;
        d_addr = 32'h30;
        d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rb_busy", mem_valid, 1);
        rst = 1;
        @(negedge clk);
        chk("rb_mem_valid", mem_valid, 0);
        chk("rb_ready", {i_ready, d_ready}, 0);
        chk("rb_err", err, 0);
        chk("rb_mem_wen", mem_wen, 0);
        chk("rb_mem_addr", mem_addr, 0);
        chk("rb_mem_wdata", mem_wdata, 0);
        rst = 0;
        d_valid = 0;
        lat = 1;
        repeat (4) @(negedge clk);
        chk("rb_no_write", writes - w0, 0);
        xfer('{1'b1, 4'hF, 32'h30, 32'hCAFEF00D, 32'h0});
        xfer('{1'b1, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D});

        // both masters held after reset: RR alternates from I, fixed priority serves D first
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        i_addr = 32'h10;
        d_addr = 32'h08;
        d_wen = 0;
        {i_valid, d_valid, i2_valid, d2_valid} = 4'hF;
        n = 0;
        k2d = 0;
        k2i = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if ((i_ready || d_ready) && n < 4) begin
                chk("rr_owner", d_ready, n % 2);
                chk("rr_cycle", k, 2 + 3 * n);
                chk("rr_data", d_ready ? d_rdata : i_rdata, (n % 2) ? 32'h1122CCDD : 32'h00018EB7);
                n++;
            end
            if (d2_ready) begin
                k2d = k;
                chk("pri_d_data", d2_rdata, 32'h08 ^ 32'hA5A50000);
                d2_valid = 0;
            end
            if (i2_ready && k2i == 0) begin
                k2i = k;
                chk("pri_i_data", i2_rdata, 32'h10 ^ 32'hA5A50000);
                i2_valid = 0;
            end
        end
        @(negedge clk);
        {i_valid, d_valid, i2_valid, d2_valid} = 4'h0;
        chk("rr_count", n, 4);
        chk("pri_d_cycle", k2d, 2);
        chk("pri_i_cycle", k2i, 5);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 64; i++) shadow[i] = mem[i];
        pi = 0;
        pd = 0;
        ai = 0;
        ad = 0;
        ia = 0;
        da = 0;
        dd = 0;
        dwn = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            chk("rnd_err", err, 0);
            if (i_ready) begin
                chk("rnd_i_pending", pi, 1);
                chk("rnd_i_data", i_rdata, shadow[ia[7:2]]);
                pi = 0;
                i_valid = 0;
            end
            if (d_ready) begin
                chk("rnd_d_pending", pd, 1);
                if (dwn == 0) chk("rnd_d_data", d_rdata, shadow[da[7:2]]);
                else shadow[da[7:2]] = merge(shadow[da[7:2]], dd, dwn);
                pd = 0;
                d_valid = 0;
            end
            if (pi && ++ai > 40) begin
                chk("rnd_i_stall", ai, 40);
                pi = 0;
                i_valid = 0;
            end
            if (pd && ++ad > 40) begin
                chk("rnd_d_stall", ad, 40);
                pd = 0;
                d_valid = 0;
            end
            if (c >= 760) continue;
            if (!mem_valid) lat = $urandom_range(1, 3);
            if (!pi && $urandom % 3 == 0) begin
                ia = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                i_addr = ia;
                i_valid = 1;
                pi = 1;
                ai = 0;
            end
            if (!pd && $urandom % 3 == 0) begin
                da = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                dwn = ($urandom % 2) ? 4'($urandom) : 4'h0;
                dd = $urandom;
                d_addr = da;
                d_wen = dwn;
                d_wdata = dd;
                d_valid = 1;
                pd = 1;
                ad = 0;
            end
        end
        chk("rnd_drained", {pi, pd}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
